// File: rtl/sd_credit_tx.sv
// Transmit side of a credit-based link. Accepts an srdy/drdy stream and forwards each
// word on a registered valid/data channel, spending one credit per word.
module sd_credit_tx #(
    parameter int width   = 8,
    parameter int credits = 4,
    localparam int cw     = $clog2(credits + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_vld,
    output logic [width-1:0] p_data,
    input  logic             p_credit,
    output logic [cw-1:0]    credit_cnt,
    output logic             credit_err
);

    localparam logic [cw-1:0] CREDIT_MAX = cw'(credits);
    localparam logic [cw-1:0] CREDIT_ONE = cw'(1);

    logic [cw-1:0]    cnt_reg, cnt_next;
    logic             drdy_reg, drdy_next;
    logic             vld_reg;
    logic [width-1:0] data_reg;
    logic             err_reg, err_next;
    logic             send;

    // drdy_reg is nonzero-count registered, so a send can never underflow the counter.
    assign send = c_srdy & drdy_reg;

    always_comb begin
        cnt_next = cnt_reg;
        err_next = err_reg;
        unique case ({send, p_credit})
            2'b10: cnt_next = cnt_reg - CREDIT_ONE;
            2'b01: begin
                // A credit beyond the receiver's depth is a protocol error; keep the count sane.
                if (cnt_reg == CREDIT_MAX) begin
                    err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CREDIT_ONE;
                end
            end
            default: cnt_next = cnt_reg;
        endcase
        drdy_next = (cnt_next != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= CREDIT_MAX;
            drdy_reg <= 1'b1;
            vld_reg  <= 1'b0;
            data_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            drdy_reg <= drdy_next;
            vld_reg  <= send;
            err_reg  <= err_next;
            if (send) begin
                data_reg <= c_data;
            end
        end
    end

    assign c_drdy     = drdy_reg;
    assign p_vld      = vld_reg;
    assign p_data     = data_reg;
    assign credit_cnt = cnt_reg;
    assign credit_err = err_reg;

endmodule

// File: tb/tb_sd_credit_tx.sv
// Directed bench for sd_credit_tx: inputs driven on the falling edge, outputs sampled
// on the falling edge before new inputs are applied.
module tb_sd_credit_tx;

    logic       clk;
    logic       reset;
    logic       c_srdy;
    logic       c_drdy;
    logic [7:0] c_data;
    logic       p_vld;
    logic [7:0] p_data;
    logic       p_credit;
    logic [2:0] credit_cnt;
    logic       credit_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sd_credit_tx #(.width(8), .credits(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .c_srdy     (c_srdy),
        .c_drdy     (c_drdy),
        .c_data     (c_data),
        .p_vld      (p_vld),
        .p_data     (p_data),
        .p_credit   (p_credit),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; c_srdy = 1'b0; c_data = 8'h00; p_credit = 1'b0;
        #12;
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL rst_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
        total_cnt++; if (c_drdy !== 1'b1) $display("FAIL rst_drdy got=%b exp=1", c_drdy); else pass_cnt++;
        total_cnt++; if (p_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", p_vld); else pass_cnt++;
        total_cnt++; if (p_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", p_data); else pass_cnt++;
        total_cnt++; if (credit_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", credit_err); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL idle_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
        total_cnt++; if (p_vld !== 1'b0) $display("FAIL idle_vld got=%b exp=0", p_vld); else pass_cnt++;
        $display("test_reset: cnt=%0d drdy=%b vld=%b err=%b", credit_cnt, c_drdy, p_vld, credit_err);
    endtask

    task automatic test_exhaust();
        logic [2:0] exp_cnt;
        c_srdy = 1'b1; c_data = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp_cnt = 3'(4 - i);
            total_cnt++; if (p_vld !== 1'b1) $display("FAIL exh_vld%0d got=%b exp=1", i, p_vld); else pass_cnt++;
            total_cnt++; if (p_data !== 8'(i)) $display("FAIL exh_data%0d got=%h exp=%h", i, p_data, 8'(i)); else pass_cnt++;
            total_cnt++; if (credit_cnt !== exp_cnt) $display("FAIL exh_cnt%0d got=%0d exp=%0d", i, credit_cnt, exp_cnt); else pass_cnt++;
            total_cnt++; if (c_drdy !== (i != 4)) $display("FAIL exh_drdy%0d got=%b exp=%b", i, c_drdy, (i != 4)); else pass_cnt++;
            $display("test_exhaust: word %0d vld=%b data=%h cnt=%0d drdy=%b", i, p_vld, p_data, credit_cnt, c_drdy);
            c_data = 8'(i + 1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++; if (p_vld !== 1'b0) $display("FAIL stall_vld%0d got=%b exp=0", i, p_vld); else pass_cnt++;
            total_cnt++; if (p_data !== 8'h04) $display("FAIL stall_data%0d got=%h exp=04", i, p_data); else pass_cnt++;
            total_cnt++; if (credit_cnt !== 3'd0) $display("FAIL stall_cnt%0d got=%0d exp=0", i, credit_cnt); else pass_cnt++;
            total_cnt++; if (c_drdy !== 1'b0) $display("FAIL stall_drdy%0d got=%b exp=0", i, c_drdy); else pass_cnt++;
            $display("test_exhaust: stall %0d vld=%b cnt=%0d drdy=%b", i, p_vld, credit_cnt, c_drdy);
        end
    endtask

    task automatic test_stall_release();
        p_credit = 1'b1;
        @(negedge clk);
        p_credit = 1'b0;
        total_cnt++; if (credit_cnt !== 3'd1) $display("FAIL rel_cnt got=%0d exp=1", credit_cnt); else pass_cnt++;
        total_cnt++; if (c_drdy !== 1'b1) $display("FAIL rel_drdy got=%b exp=1", c_drdy); else pass_cnt++;
        total_cnt++; if (p_vld !== 1'b0) $display("FAIL rel_vld got=%b exp=0", p_vld); else pass_cnt++;
        $display("test_stall_release: credit cnt=%0d drdy=%b", credit_cnt, c_drdy);
        @(negedge clk);
        c_srdy = 1'b0;
        total_cnt++; if (p_vld !== 1'b1) $display("FAIL rel_send_vld got=%b exp=1", p_vld); else pass_cnt++;
        total_cnt++; if (p_data !== 8'h05) $display("FAIL rel_send_data got=%h exp=05", p_data); else pass_cnt++;
        total_cnt++; if (credit_cnt !== 3'd0) $display("FAIL rel_send_cnt got=%0d exp=0", credit_cnt); else pass_cnt++;
        total_cnt++; if (c_drdy !== 1'b0) $display("FAIL rel_send_drdy got=%b exp=0", c_drdy); else pass_cnt++;
        $display("test_stall_release: send data=%h cnt=%0d drdy=%b", p_data, credit_cnt, c_drdy);
    endtask

    task automatic test_back_to_back();
        p_credit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (credit_cnt !== 3'd2) $display("FAIL b2b_pre_cnt got=%0d exp=2", credit_cnt); else pass_cnt++;
        c_srdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c_data = 8'(8'h10 + i);
            @(negedge clk);
            total_cnt++; if (p_vld !== 1'b1) $display("FAIL b2b_vld%0d got=%b exp=1", i, p_vld); else pass_cnt++;
            total_cnt++; if (p_data !== 8'(8'h10 + i)) $display("FAIL b2b_data%0d got=%h exp=%h", i, p_data, 8'(8'h10 + i)); else pass_cnt++;
            total_cnt++; if (credit_cnt !== 3'd2) $display("FAIL b2b_cnt%0d got=%0d exp=2", i, credit_cnt); else pass_cnt++;
            $display("test_back_to_back: %0d vld=%b data=%h cnt=%0d", i, p_vld, p_data, credit_cnt);
        end
        c_srdy = 1'b0; p_credit = 1'b0;
        @(negedge clk);
        total_cnt++; if (p_vld !== 1'b0) $display("FAIL b2b_end_vld got=%b exp=0", p_vld); else pass_cnt++;
        total_cnt++; if (p_data !== 8'h19) $display("FAIL b2b_end_data got=%h exp=19", p_data); else pass_cnt++;
    endtask

    task automatic test_overflow();
        p_credit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL ovf_full_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
        total_cnt++; if (credit_err !== 1'b0) $display("FAIL ovf_pre_err got=%b exp=0", credit_err); else pass_cnt++;
        @(negedge clk);
        p_credit = 1'b0;
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL ovf_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
        total_cnt++; if (credit_err !== 1'b1) $display("FAIL ovf_err got=%b exp=1", credit_err); else pass_cnt++;
        $display("test_overflow: cnt=%0d err=%b", credit_cnt, credit_err);
        c_srdy = 1'b1; c_data = 8'h20;
        @(negedge clk);
        c_srdy = 1'b0;
        @(negedge clk);
        total_cnt++; if (credit_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", credit_err); else pass_cnt++;
        total_cnt++; if (credit_cnt !== 3'd3) $display("FAIL ovf_send_cnt got=%0d exp=3", credit_cnt); else pass_cnt++;
        $display("test_overflow: sticky err=%b cnt=%0d", credit_err, credit_cnt);
    endtask

    task automatic test_reset_mid();
        c_srdy = 1'b1; c_data = 8'h30;
        @(negedge clk);
        c_data = 8'h31;
        @(negedge clk);
        c_data = 8'h32;
        total_cnt++; if (credit_cnt !== 3'd1) $display("FAIL mid_pre_cnt got=%0d exp=1", credit_cnt); else pass_cnt++;
        total_cnt++; if (p_vld !== 1'b1) $display("FAIL mid_pre_vld got=%b exp=1", p_vld); else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++; if (p_vld !== 1'b0) $display("FAIL mid_vld got=%b exp=0", p_vld); else pass_cnt++;
        total_cnt++; if (c_drdy !== 1'b1) $display("FAIL mid_drdy got=%b exp=1", c_drdy); else pass_cnt++;
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL mid_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
        total_cnt++; if (credit_err !== 1'b0) $display("FAIL mid_err got=%b exp=0", credit_err); else pass_cnt++;
        $display("test_reset_mid: vld=%b drdy=%b cnt=%0d err=%b", p_vld, c_drdy, credit_cnt, credit_err);
        c_srdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (credit_cnt !== 3'd4) $display("FAIL mid_post_cnt got=%0d exp=4", credit_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_stall_release();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
